fs_bufmgr: RTL and testbench
============================

FS_BUFMGR -- requirements
Module: fs_bufmgr

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- C_ADDR_WIDTH, 32, buffer address width.
- C_BUF0_ADDR, 'h3F000000, base address of buffer 0.
- C_BUF1_ADDR, 'h3F100000, base address of buffer 1.
- C_BUF2_ADDR, 'h3F200000, base address of buffer 2.
- C_BUF3_ADDR, 'h3F300000, base address of buffer 3.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- resetn, in, 1, asynchronous active-low reset.
- soft_resetn, in, 1, synchronous active-low clear (from register block).
- wr_sof, in, 1, writer frame-start pulse.
- wr_eof, in, 1, writer frame-complete pulse.
- rd_sof, in, 1, reader frame-start pulse (display fsync).
- wr_busy, out, 1, writer owns a buffer.
- wr_idx, out, 2, writer buffer index.
- wr_addr, out, C_ADDR_WIDTH, writer buffer base address.
- rd_valid, out, 1, reader holds a completed frame.
- rd_idx, out, 2, reader buffer index.
- rd_addr, out, C_ADDR_WIDTH, reader buffer base address.
- rd_new, out, 1, one-cycle pulse when the reader switches buffer.
- drop_cnt, out, 16, saturating dropped-frame count.

Function
REQ-003 The block SHALL share four buffers between one writer and one reader with state: writer FSM {W_IDLE, W_BUSY}, ready slot {ready_vld, ready_idx}, reader slot {rd_valid, rd_idx}.
REQ-004 All outputs SHALL be registered; every response appears on the cycle after the input pulse (latency 1).
REQ-005 wr_addr/rd_addr SHALL equal C_BUFn_ADDR selected by wr_idx/rd_idx.
REQ-006 wr_eof in W_BUSY SHALL set ready_idx<=wr_idx, ready_vld<=1, state W_IDLE; wr_eof in W_IDLE SHALL be ignored.
REQ-007 wr_eof while ready_vld=1 and no same-cycle rd_sof SHALL overwrite the ready slot and increment drop_cnt.
REQ-008 wr_sof SHALL enter W_BUSY with wr_idx = lowest index not in {rd_idx if rd_valid after this cycle, ready_idx if ready_vld after this cycle}; with two exclusions at most, a free index always exists.
REQ-009 wr_sof in W_BUSY without same-cycle wr_eof SHALL abort the frame: drop_cnt increments and a new buffer is chosen per REQ-008.
REQ-010 Same-cycle wr_eof and wr_sof SHALL process eof first, then sof; the just-completed buffer is excluded from selection.
REQ-011 rd_sof with ready_vld=1 SHALL set rd_idx<=ready_idx, rd_valid<=1, ready_vld<=0, and pulse rd_new.
REQ-012 rd_sof with ready_vld=0 SHALL leave rd_idx and rd_valid unchanged, with rd_new=0.
REQ-013 Same-cycle wr_eof and rd_sof SHALL hand the completing wr_idx directly to the reader, leave ready_vld=0, and not count a drop.
REQ-014 drop_cnt SHALL saturate at 16'hFFFF; two drop events in one cycle SHALL count once.
REQ-015 wr_idx SHALL never equal rd_idx while wr_busy=1 and rd_valid=1.

Reset
REQ-016 resetn low SHALL asynchronously force: W_IDLE, wr_busy=0, wr_idx=0, rd_idx=0, rd_valid=0, ready_vld=0, rd_new=0, drop_cnt=0, wr_addr=rd_addr=C_BUF0_ADDR.
REQ-017 soft_resetn low at a clock edge SHALL apply the same values synchronously, including mid-frame, and SHALL override all pulses in that cycle.

Verification
REQ-018 Reset release, no pulses -> wr_idx=0, wr_addr=0x3F000000, rd_valid=0, drop_cnt=0.
REQ-019 wr_sof; wr_eof; rd_sof -> wr_idx=0; then rd_idx=0, rd_new=1 for one cycle, rd_addr=0x3F000000; next wr_sof -> wr_idx=1.
REQ-020 Frames in buf0 and buf1 complete with no rd_sof -> drop_cnt=1; rd_sof -> rd_idx=1.
REQ-021 wr_eof and rd_sof in the same cycle (writing buf2) -> rd_idx=2, drop_cnt unchanged, ready_vld=0.
REQ-022 wr_sof twice without wr_eof -> drop_cnt=1, wr_busy stays 1; rd_sof with nothing ready -> rd_new=0, rd_idx unchanged.
REQ-023 soft_resetn low for one cycle mid-frame with drop_cnt=5 -> next cycle all outputs at reset values, drop_cnt=0.

Source files
------------

// File: rtl/fs_bufmgr_if.sv
// Frame-buffer manager handshake bundle: writer/reader frame pulses in, buffer
// ownership, addresses and the dropped-frame count out.
interface fs_bufmgr_if #(
    parameter int C_ADDR_WIDTH = 32
);
    logic                    wr_sof;
    logic                    wr_eof;
    logic                    rd_sof;
    logic                    wr_busy;
    logic [1:0]              wr_idx;
    logic [C_ADDR_WIDTH-1:0] wr_addr;
    logic                    rd_valid;
    logic [1:0]              rd_idx;
    logic [C_ADDR_WIDTH-1:0] rd_addr;
    logic                    rd_new;
    logic [15:0]             drop_cnt;

    modport master (
        output wr_sof, wr_eof, rd_sof,
        input  wr_busy, wr_idx, wr_addr, rd_valid, rd_idx, rd_addr, rd_new, drop_cnt
    );

    modport slave (
        input  wr_sof, wr_eof, rd_sof,
        output wr_busy, wr_idx, wr_addr, rd_valid, rd_idx, rd_addr, rd_new, drop_cnt
    );
endinterface

// File: rtl/fs_bufmgr.sv
// Four-buffer frame store manager: one writer, one reader, a single "ready"
// slot between them. All outputs are registered one cycle after the pulses.
module fs_bufmgr #(
    parameter int                    C_ADDR_WIDTH = 32,
    parameter logic [C_ADDR_WIDTH-1:0] C_BUF0_ADDR  = 'h3F000000,
    parameter logic [C_ADDR_WIDTH-1:0] C_BUF1_ADDR  = 'h3F100000,
    parameter logic [C_ADDR_WIDTH-1:0] C_BUF2_ADDR  = 'h3F200000,
    parameter logic [C_ADDR_WIDTH-1:0] C_BUF3_ADDR  = 'h3F300000
) (
    input logic        clk,
    input logic        resetn,
    input logic        soft_resetn,
    fs_bufmgr_if.slave bus
);

    typedef enum logic {W_IDLE, W_BUSY} wstate_t;

    wstate_t                 state_reg, state_next;
    logic                    wr_busy_reg, wr_busy_next;
    logic [1:0]              wr_idx_reg, wr_idx_next;
    logic [C_ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic                    ready_vld_reg, ready_vld_next;
    logic [1:0]              ready_idx_reg, ready_idx_next;
    logic                    rd_valid_reg, rd_valid_next;
    logic [1:0]              rd_idx_reg, rd_idx_next;
    logic [C_ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
    logic                    rd_new_reg, rd_new_next;
    logic [15:0]             drop_cnt_reg, drop_cnt_next;

    logic       eof_ev;
    logic       overwrite_drop;
    logic       abort_drop;
    logic [3:0] in_use;
    logic [1:0] free_idx;

    function automatic logic [C_ADDR_WIDTH-1:0] addr_of(input logic [1:0] idx);
        case (idx)
            2'd0:    addr_of = C_BUF0_ADDR;
            2'd1:    addr_of = C_BUF1_ADDR;
            2'd2:    addr_of = C_BUF2_ADDR;
            default: addr_of = C_BUF3_ADDR;
        endcase
    endfunction

    assign eof_ev = bus.wr_eof && (state_reg == W_BUSY);

    // Completion is resolved first: ready slot and reader slot for the end of this cycle.
    always_comb begin
        ready_vld_next = ready_vld_reg;
        ready_idx_next = ready_idx_reg;
        rd_valid_next  = rd_valid_reg;
        rd_idx_next    = rd_idx_reg;
        rd_new_next    = 1'b0;
        overwrite_drop = 1'b0;
        if (eof_ev) begin
            if (bus.rd_sof) begin
                // Reader takes the just-finished buffer directly; ready slot is retired.
                rd_idx_next    = wr_idx_reg;
                rd_valid_next  = 1'b1;
                rd_new_next    = 1'b1;
                ready_vld_next = 1'b0;
            end else begin
                overwrite_drop = ready_vld_reg;
                ready_vld_next = 1'b1;
                ready_idx_next = wr_idx_reg;
            end
        end else if (bus.rd_sof && ready_vld_reg) begin
            rd_idx_next    = ready_idx_reg;
            rd_valid_next  = 1'b1;
            rd_new_next    = 1'b1;
            ready_vld_next = 1'b0;
        end
    end

    // A buffer is busy if the reader or the ready slot will hold it after this cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_in_use
            assign in_use[gi] = (rd_valid_next  && (rd_idx_next    == 2'(gi))) ||
                                (ready_vld_next && (ready_idx_next == 2'(gi)));
        end
    endgenerate

    always_comb begin
        free_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!in_use[i]) begin
                free_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        wr_idx_next = wr_idx_reg;
        abort_drop  = 1'b0;
        if (eof_ev) begin
            state_next = W_IDLE;
        end
        if (bus.wr_sof) begin
            abort_drop  = (state_reg == W_BUSY) && !bus.wr_eof;
            state_next  = W_BUSY;
            wr_idx_next = free_idx;
        end
        wr_busy_next  = (state_next == W_BUSY);
        wr_addr_next  = addr_of(wr_idx_next);
        rd_addr_next  = addr_of(rd_idx_next);
        drop_cnt_next = drop_cnt_reg;
        if ((overwrite_drop || abort_drop) && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_next = drop_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= W_IDLE;
            wr_busy_reg   <= 1'b0;
            wr_idx_reg    <= 2'd0;
            wr_addr_reg   <= C_BUF0_ADDR;
            ready_vld_reg <= 1'b0;
            ready_idx_reg <= 2'd0;
            rd_valid_reg  <= 1'b0;
            rd_idx_reg    <= 2'd0;
            rd_addr_reg   <= C_BUF0_ADDR;
            rd_new_reg    <= 1'b0;
            drop_cnt_reg  <= 16'd0;
        end else if (!soft_resetn) begin
            state_reg     <= W_IDLE;
            wr_busy_reg   <= 1'b0;
            wr_idx_reg    <= 2'd0;
            wr_addr_reg   <= C_BUF0_ADDR;
            ready_vld_reg <= 1'b0;
            ready_idx_reg <= 2'd0;
            rd_valid_reg  <= 1'b0;
            rd_idx_reg    <= 2'd0;
            rd_addr_reg   <= C_BUF0_ADDR;
            rd_new_reg    <= 1'b0;
            drop_cnt_reg  <= 16'd0;
        end else begin
            state_reg     <= state_next;
            wr_busy_reg   <= wr_busy_next;
            wr_idx_reg    <= wr_idx_next;
            wr_addr_reg   <= wr_addr_next;
            ready_vld_reg <= ready_vld_next;
            ready_idx_reg <= ready_idx_next;
            rd_valid_reg  <= rd_valid_next;
            rd_idx_reg    <= rd_idx_next;
            rd_addr_reg   <= rd_addr_next;
            rd_new_reg    <= rd_new_next;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    assign bus.wr_busy  = wr_busy_reg;
    assign bus.wr_idx   = wr_idx_reg;
    assign bus.wr_addr  = wr_addr_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_idx   = rd_idx_reg;
    assign bus.rd_addr  = rd_addr_reg;
    assign bus.rd_new   = rd_new_reg;
    assign bus.drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_fs_bufmgr.sv
// Directed bench for fs_bufmgr: each driven cycle pushes its expected outputs,
// a monitor pops and compares them one cycle later.
module tb_fs_bufmgr;

    logic clk;
    logic resetn;
    logic soft_resetn;

    fs_bufmgr_if #(.C_ADDR_WIDTH(32)) bus ();

    fs_bufmgr dut (
        .clk         (clk),
        .resetn      (resetn),
        .soft_resetn (soft_resetn),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          num;
        logic        busy;
        logic [1:0]  widx;
        logic        rv;
        logic [1:0]  ridx;
        logic        rnew;
        logic [15:0] drop;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   txn      = 0;

    logic [31:0] addr_tab [4];
    initial begin
        addr_tab[0] = 32'h3F000000;
        addr_tab[1] = 32'h3F100000;
        addr_tab[2] = 32'h3F200000;
        addr_tab[3] = 32'h3F300000;
    end

    task automatic chk(input int num, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL txn %0d %s: got 0x%0h expected 0x%0h", num, name, act, req);
        end
    endtask

    // Monitor: outputs are sampled 1ns after the edge that registered them.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (bus.wr_busy === 1'b1 && bus.rd_valid === 1'b1) begin
            n_checks++;
            if (bus.wr_idx === bus.rd_idx) begin
                n_fail++;
                $display("FAIL overlap: wr_idx %0d equals rd_idx %0d", bus.wr_idx, bus.rd_idx);
            end
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.num, "wr_busy",  32'(bus.wr_busy),  32'(e.busy));
            chk(e.num, "wr_idx",   32'(bus.wr_idx),   32'(e.widx));
            chk(e.num, "wr_addr",  bus.wr_addr,       addr_tab[e.widx]);
            chk(e.num, "rd_valid", 32'(bus.rd_valid), 32'(e.rv));
            chk(e.num, "rd_idx",   32'(bus.rd_idx),   32'(e.ridx));
            chk(e.num, "rd_addr",  bus.rd_addr,       addr_tab[e.ridx]);
            chk(e.num, "rd_new",   32'(bus.rd_new),   32'(e.rnew));
            chk(e.num, "drop_cnt", 32'(bus.drop_cnt), 32'(e.drop));
            $display("txn %0d: busy=%0b widx=%0d rv=%0b ridx=%0d new=%0b drop=%0d",
                     e.num, bus.wr_busy, bus.wr_idx, bus.rd_valid, bus.rd_idx, bus.rd_new, bus.drop_cnt);
        end
    end

    task automatic cyc(input bit ws, input bit we, input bit rs, input bit srst,
                       input bit eb, input logic [1:0] ew, input bit erv,
                       input logic [1:0] er, input bit en, input logic [15:0] ed);
        exp_t e;
        @(negedge clk);
        bus.wr_sof  = ws;
        bus.wr_eof  = we;
        bus.rd_sof  = rs;
        soft_resetn = !srst;
        txn++;
        e.num = txn; e.busy = eb; e.widx = ew; e.rv = erv;
        e.ridx = er; e.rnew = en; e.drop = ed;
        sb.push_back(e);
    endtask

    initial begin
        resetn      = 1'b0;
        soft_resetn = 1'b1;
        bus.wr_sof  = 1'b0;
        bus.wr_eof  = 1'b0;
        bus.rd_sof  = 1'b0;
        //   sof eof rsof srst | busy widx rv ridx new drop
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);   // held in reset
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);   // idle after release
        cyc(1, 0, 0, 0,   1, 0, 0, 0, 0, 0);   // first frame into buf0
        cyc(0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0,   0, 0, 1, 0, 1, 0);   // reader takes buf0
        cyc(0, 0, 0, 0,   0, 0, 1, 0, 0, 0);   // rd_new is one cycle
        cyc(1, 0, 0, 0,   1, 1, 1, 0, 0, 0);   // buf0 excluded
        cyc(0, 1, 0, 0,   0, 1, 1, 0, 0, 0);   // buf1 ready
        cyc(1, 0, 0, 0,   1, 2, 1, 0, 0, 0);   // buf0, buf1 excluded
        cyc(0, 1, 1, 0,   0, 2, 1, 2, 1, 0);   // eof+rd_sof: direct handoff, no drop
        cyc(0, 0, 1, 0,   0, 2, 1, 2, 0, 0);   // nothing ready
        cyc(1, 0, 0, 0,   1, 0, 1, 2, 0, 0);   // ready slot empty again -> buf0
        cyc(1, 0, 0, 0,   1, 0, 1, 2, 0, 1);   // abort
        cyc(1, 1, 0, 0,   1, 1, 1, 2, 0, 1);   // eof then sof: buf0 ready, pick buf1
        cyc(0, 1, 0, 0,   0, 1, 1, 2, 0, 2);   // overwrite ready slot
        cyc(0, 1, 0, 0,   0, 1, 1, 2, 0, 2);   // eof while idle ignored
        cyc(1, 0, 1, 0,   1, 0, 1, 1, 1, 2);   // reader takes buf1, writer buf0
        cyc(1, 0, 0, 0,   1, 0, 1, 1, 0, 3);
        cyc(1, 0, 0, 0,   1, 0, 1, 1, 0, 4);
        cyc(1, 0, 0, 0,   1, 0, 1, 1, 0, 5);
        cyc(1, 1, 1, 1,   0, 0, 0, 0, 0, 0);   // soft reset beats all pulses
        cyc(1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0,   1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0,   0, 1, 0, 0, 0, 1);   // buf0 frame dropped
        cyc(0, 0, 1, 0,   0, 1, 1, 1, 1, 1);
        cyc(1, 0, 0, 0,   1, 0, 1, 1, 0, 1);
        cyc(1, 0, 0, 0,   1, 0, 1, 1, 0, 2);   // abort, then hard reset
        @(negedge clk);
        bus.wr_sof = 1'b0;
        resetn     = 1'b0;
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
